// File: rtl/soc_crc32_checker_if.sv
// rtl/soc_crc32_checker_if.sv - byte stream in, frame result out, for the CRC-32 checker
interface soc_crc32_checker_if;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_last;
    logic        in_ready;
    logic        result_valid;
    logic        crc_ok;
    logic        crc_err;
    logic        short_frame;
    logic [31:0] computed_crc;
    logic [31:0] received_crc;

    modport master (
        output in_data, in_valid, in_last,
        input  in_ready, result_valid, crc_ok, crc_err, short_frame,
               computed_crc, received_crc
    );

    modport slave (
        input  in_data, in_valid, in_last,
        output in_ready, result_valid, crc_ok, crc_err, short_frame,
               computed_crc, received_crc
    );
endinterface

// File: rtl/soc_crc32_checker.sv
// rtl/soc_crc32_checker.sv - receive-side CRC-32 checker, bit-serial engine behind a 4-byte delay line
module soc_crc32_checker #(
    parameter logic [31:0] POLYNOMIAL = 32'h1EDC6F41,
    parameter logic [31:0] INIT       = 32'hFFFFFFFF,
    parameter logic [31:0] FINAL_XOR  = 32'hFFFFFFFF
) (
    input logic                  clk,
    input logic                  res,
    soc_crc32_checker_if.slave   s_if
);

    typedef enum logic [1:0] {
        ST_ACCEPT = 2'd0,
        ST_SHIFT  = 2'd1,
        ST_CHECK  = 2'd2
    } state_t;

    state_t      state_q;
    logic [31:0] crc_q;
    logic [7:0]  buf_q;
    logic [3:0]  bitcnt_q;
    logic [2:0]  fill_q;
    logic        last_pending_q;
    logic [7:0]  dline_q [4];

    logic        result_valid_q;
    logic        crc_ok_q;
    logic        crc_err_q;
    logic        short_frame_q;
    logic [31:0] computed_crc_q;
    logic [31:0] received_crc_q;

    logic        fb;
    logic [31:0] crc_d;
    logic [31:0] crc_out;
    logic [31:0] rx_crc;
    logic        is_short;

    assign fb    = buf_q[0] ^ crc_q[31];
    assign crc_d = fb ? {crc_q[30:0] ^ POLYNOMIAL[31:1], 1'b1} : {crc_q[30:0], 1'b0};

    // Register is shifted MSB-first, so the reported CRC is its bit reversal.
    always_comb begin
        crc_out = '0;
        for (int i = 0; i < 32; i++) begin
            crc_out[i] = crc_q[31-i] ^ FINAL_XOR[i];
        end
    end

    assign rx_crc   = {dline_q[3], dline_q[2], dline_q[1], dline_q[0]};
    assign is_short = (fill_q != 3'd4);

    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            state_q        <= ST_ACCEPT;
            crc_q          <= INIT;
            buf_q          <= '0;
            bitcnt_q       <= '0;
            fill_q         <= '0;
            last_pending_q <= 1'b0;
            for (int i = 0; i < 4; i++) dline_q[i] <= '0;
            result_valid_q <= 1'b0;
            crc_ok_q       <= 1'b0;
            crc_err_q      <= 1'b0;
            short_frame_q  <= 1'b0;
            computed_crc_q <= '0;
            received_crc_q <= '0;
        end else begin
            result_valid_q <= 1'b0;
            case (state_q)
                ST_ACCEPT: begin
                    if (s_if.in_valid) begin
                        if (fill_q != 3'd4) begin
                            dline_q[fill_q[1:0]] <= s_if.in_data;
                            fill_q               <= fill_q + 3'd1;
                            if (s_if.in_last) state_q <= ST_CHECK;
                        end else begin
                            // Oldest held byte is now known to be payload.
                            buf_q      <= dline_q[0];
                            dline_q[0] <= dline_q[1];
                            dline_q[1] <= dline_q[2];
                            dline_q[2] <= dline_q[3];
                            dline_q[3] <= s_if.in_data;
                            bitcnt_q   <= 4'd8;
                            state_q    <= ST_SHIFT;
                        end
                        if (s_if.in_last) last_pending_q <= 1'b1;
                    end
                end
                ST_SHIFT: begin
                    crc_q    <= crc_d;
                    buf_q    <= buf_q >> 1;
                    bitcnt_q <= bitcnt_q - 4'd1;
                    if (bitcnt_q == 4'd1) begin
                        state_q <= last_pending_q ? ST_CHECK : ST_ACCEPT;
                    end
                end
                ST_CHECK: begin
                    result_valid_q <= 1'b1;
                    short_frame_q  <= is_short;
                    crc_ok_q       <= !is_short && (crc_out == rx_crc);
                    crc_err_q      <= !(!is_short && (crc_out == rx_crc));
                    computed_crc_q <= crc_out;
                    received_crc_q <= rx_crc;
                    crc_q          <= INIT;
                    fill_q         <= '0;
                    last_pending_q <= 1'b0;
                    for (int i = 0; i < 4; i++) dline_q[i] <= '0;
                    state_q        <= ST_ACCEPT;
                end
                default: state_q <= ST_ACCEPT;
            endcase
        end
    end

    assign s_if.in_ready     = (state_q == ST_ACCEPT);
    assign s_if.result_valid = result_valid_q;
    assign s_if.crc_ok       = crc_ok_q;
    assign s_if.crc_err      = crc_err_q;
    assign s_if.short_frame  = short_frame_q;
    assign s_if.computed_crc = computed_crc_q;
    assign s_if.received_crc = received_crc_q;

endmodule

// File: tb/tb_soc_crc32_checker.sv
// tb/tb_soc_crc32_checker.sv - table-driven frame checks plus reset/throughput sequences
module tb_soc_crc32_checker;

    logic clk;
    logic res;

    soc_crc32_checker_if u_if ();

    soc_crc32_checker u_dut (
        .clk  (clk),
        .res  (res),
        .s_if (u_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string        name;
        logic [103:0] bytes;   // byte 0 in bits [7:0]
        int           len;
        logic         exp_ok;
        logic         exp_err;
        logic         exp_short;
        logic [31:0]  exp_comp;
        logic [31:0]  exp_rec;
        int           exp_lat;
    } vec_t;

    vec_t vecs [7];
    int   checks;
    int   errors;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Called and returns just after a falling edge; 'waited' counts cycles with in_ready low.
    task automatic send_byte(input logic [7:0] d, input logic l, output int waited);
        u_if.in_data  = d;
        u_if.in_last  = l;
        u_if.in_valid = 1'b1;
        waited = 0;
        while (!u_if.in_ready && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        @(negedge clk);
        u_if.in_valid = 1'b0;
        u_if.in_last  = 1'b0;
    endtask

    task automatic run_frame(input vec_t v);
        int w;
        int lat;
        for (int i = 0; i < v.len; i++) begin
            send_byte(v.bytes[8*i +: 8], (i == v.len - 1), w);
            chk($sformatf("%s ready_wait[%0d]", v.name, i), w, (i >= 5) ? 8 : 0);
        end
        lat = 0;
        while (!u_if.result_valid && lat < 200) begin
            @(negedge clk);
            lat++;
        end
        chk({v.name, " latency"},      lat,               v.exp_lat);
        chk({v.name, " crc_ok"},       u_if.crc_ok,       v.exp_ok);
        chk({v.name, " crc_err"},      u_if.crc_err,      v.exp_err);
        chk({v.name, " short_frame"},  u_if.short_frame,  v.exp_short);
        chk({v.name, " computed_crc"}, u_if.computed_crc, v.exp_comp);
        chk({v.name, " received_crc"}, u_if.received_crc, v.exp_rec);
        @(negedge clk);
        chk({v.name, " pulse_width"},  u_if.result_valid, 1'b0);
        chk({v.name, " held_ok"},      u_if.crc_ok,       v.exp_ok);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        int pulses;
        checks = 0;
        errors = 0;

        vecs[0] = '{"good",     {8'hE3, 8'h06, 8'h92, 8'h83, "987654321"}, 13, 1'b1, 1'b0, 1'b0, 32'hE3069283, 32'hE3069283, 9};
        vecs[1] = '{"badmsb",   {8'hE2, 8'h06, 8'h92, 8'h83, "987654321"}, 13, 1'b0, 1'b1, 1'b0, 32'hE3069283, 32'hE2069283, 9};
        vecs[2] = '{"empty",    104'h0,                                    4,  1'b1, 1'b0, 1'b0, 32'h00000000, 32'h00000000, 1};
        vecs[3] = '{"short3",   104'hCCBBAA,                               3,  1'b0, 1'b1, 1'b1, 32'h00000000, 32'h00CCBBAA, 1};
        vecs[4] = '{"badlsb",   {8'hE3, 8'h06, 8'h92, 8'h84, "987654321"}, 13, 1'b0, 1'b1, 1'b0, 32'hE3069283, 32'hE3069284, 9};
        vecs[5] = '{"short1",   104'h5A,                                   1,  1'b0, 1'b1, 1'b1, 32'h00000000, 32'h0000005A, 1};
        vecs[6] = '{"emptybad", 104'h44332211,                             4,  1'b0, 1'b1, 1'b0, 32'h00000000, 32'h44332211, 1};

        u_if.in_data  = '0;
        u_if.in_valid = 1'b0;
        u_if.in_last  = 1'b0;
        res = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset in_ready",     u_if.in_ready,     1'b1);
        chk("reset result_valid", u_if.result_valid, 1'b0);
        chk("reset crc_ok",       u_if.crc_ok,       1'b0);
        chk("reset crc_err",      u_if.crc_err,      1'b0);
        chk("reset short_frame",  u_if.short_frame,  1'b0);
        chk("reset computed_crc", u_if.computed_crc, 32'h0);
        chk("reset received_crc", u_if.received_crc, 32'h0);
        res = 1'b1;
        @(negedge clk);

        for (int k = 0; k < 7; k++) begin
            run_frame(vecs[k]);
        end

        // Abort a frame mid-shift; only the following complete frame may report.
        for (int i = 0; i < 6; i++) begin
            send_byte(vecs[0].bytes[8*i +: 8], 1'b0, w);
        end
        chk("abort in_ready before reset", u_if.in_ready, 1'b0);
        res = 1'b0;
        #1;
        chk("abort in_ready in reset",   u_if.in_ready,     1'b1);
        chk("abort computed_crc reset",  u_if.computed_crc, 32'h0);
        chk("abort crc_err reset",       u_if.crc_err,      1'b0);
        @(negedge clk);
        res = 1'b1;
        pulses = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (u_if.result_valid) pulses++;
        end
        chk("abort no result", pulses, 0);
        run_frame(vecs[0]);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
